// File: rtl/hmmm_pkg.sv
`default_nettype none
// =============================================================================
// Module      : hmmm_pkg
// Description : Shared types and constants for the Hmmm memory bridge.
// Revision    : 1.0 - initial release
// =============================================================================
package hmmm_pkg;

    localparam int HMMM_DATA_WIDTH = 16;
    localparam int HMMM_ADDR_WIDTH = 8;
    localparam int HMMM_TIMEOUT    = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage : hmmm_pkg
`default_nettype wire

// File: rtl/memory_port_if.sv
`default_nettype none
// =============================================================================
// Module      : memory_port_if
// Description : Request/acknowledge link between the bridge and external memory.
// Revision    : 1.0 - initial release
// =============================================================================
interface memory_port_if
    import hmmm_pkg::*;
#(
    parameter int DATA_WIDTH = HMMM_DATA_WIDTH,
    parameter int ADDR_WIDTH = HMMM_ADDR_WIDTH
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface : memory_port_if
`default_nettype wire

// File: rtl/memory_port_wait_timer.sv
`default_nettype none
// =============================================================================
// Module      : wait_timer
// Description : Wait-state counter; flags the cycle whose count reaches TIMEOUT.
// Revision    : 1.0 - initial release
// =============================================================================
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_last = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Asserted during the request cycle whose increment would bring the count to TIMEOUT.
    assign expired = enable && (r_count == c_last);

endmodule : wait_timer
`default_nettype wire

// File: rtl/memory_port.sv
`default_nettype none
// =============================================================================
// Module      : memory_port
// Description : Bus-side memory bridge: MAR load, store and load over req/ack,
//               with the load result driven back onto the shared tristate bus.
// Revision    : 1.0 - initial release
// =============================================================================
module memory_port
    import hmmm_pkg::*;
#(
    parameter int DATA_WIDTH = HMMM_DATA_WIDTH,
    parameter int ADDR_WIDTH = HMMM_ADDR_WIDTH,
    parameter int TIMEOUT    = HMMM_TIMEOUT
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  addr_in,
    input  wire logic                  mem_in,
    input  wire logic                  mem_out,
    inout  wire       [DATA_WIDTH-1:0] data,
    output logic                       busy,
    output logic                       err,
    memory_port_if.master              mem
);
    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_mar;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rbuf;
    logic                  r_err;
    logic                  w_req;
    logic                  w_we;
    logic                  w_busy;
    logic                  w_access;
    logic                  w_clear;
    logic                  w_enable;
    logic                  w_expired;
    logic                  w_conflict;
    logic                  w_drive;

    assign w_access   = (r_state == ST_WR) || (r_state == ST_RD);
    assign w_clear    = (r_state == ST_IDLE);
    assign w_enable   = w_access && !mem.mem_ack;
    assign w_conflict = (addr_in && (mem_in || mem_out)) || (mem_in && mem_out);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .enable  (w_enable),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (addr_in)      w_next = ST_IDLE;
                else if (mem_in)  w_next = ST_WR;
                else if (mem_out) w_next = ST_RD;
            end
            ST_WR: begin
                if (mem.mem_ack || w_expired) w_next = ST_IDLE;
            end
            ST_RD: begin
                if (mem.mem_ack)    w_next = ST_HOLD;
                else if (w_expired) w_next = ST_IDLE;
            end
            ST_HOLD: begin
                if (!mem_out) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req  = 1'b0;
        w_we   = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            ST_WR: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_busy = 1'b1;
            end
            ST_RD: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
            end
            default: begin
                w_req  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mar   <= '0;
            r_wdata <= '0;
            r_rbuf  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (addr_in)     r_mar   <= data[ADDR_WIDTH-1:0];
                else if (mem_in) r_wdata <= data;
                if (w_conflict)  r_err   <= 1'b1;
            end
            if ((r_state == ST_RD) && mem.mem_ack) r_rbuf <= mem.mem_rdata;
            if (w_expired) r_err <= 1'b1;
        end
    end

    // Drive enable is combinational so the bus is released the moment mem_out falls.
    assign w_drive = (r_state == ST_HOLD) && mem_out;
    assign data    = w_drive ? r_rbuf : {DATA_WIDTH{1'bz}};

    assign busy          = w_busy;
    assign err           = r_err;
    assign mem.mem_req   = w_req;
    assign mem.mem_we    = w_we;
    assign mem.mem_addr  = r_mar;
    assign mem.mem_wdata = r_wdata;

endmodule : memory_port
`default_nettype wire
